// File: rtl/emac_tx_ctrl.sv
// ---------------------------------------------------------------------------
// emac_tx_ctrl
//   Moves byte-wide frames from the TX frame buffer stream onto the EMAC TX
//   client port. Handles the first-byte/ACK handshake, flags underrun on
//   source starvation, and aborts and drains a frame on collision. It also
//   holds the IFG delay register and four saturating event counters.
//
// Ports
//   CLK, RESET          clock, asynchronous active-low reset
//   ENABLE              permit start of new frames
//   IN_*                source stream (data, SOF, EOF, valid) / IN_DST_RDY consume
//   EMAC_DATA/DVLD      byte and valid to EMAC
//   EMAC_ACK            EMAC accepted first byte
//   EMAC_FIRSTBYTE      first byte pending ACK
//   EMAC_UNDERRUN       one-cycle abort on starvation
//   EMAC_COLLISION      collision abort, EMAC_RETRANSMIT qualifies it
//   EMAC_IFGDELAY       IFG delay register, loaded from CFG_IFG on CFG_IFG_WE
//   CNT_CLR             synchronous clear of all counters
//   CNT_*               frames / underruns / collisions / retransmits
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | between frames; drops stray non-SOF bytes
// WAIT_ACK | first byte presented with FIRSTBYTE, held until EMAC_ACK
// SEND     | streaming bytes, one per cycle
// DRAIN    | frame aborted; discard source bytes up to and incl. EOF
// ---------------------------------------------------------------------------
module emac_tx_ctrl #(
    parameter int         CNT_WIDTH   = 32,
    parameter logic [7:0] IFG_DEFAULT = 8'd0
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 ENABLE,
    input  logic [7:0]           IN_DATA,
    input  logic                 IN_SOF,
    input  logic                 IN_EOF,
    input  logic                 IN_SRC_RDY,
    output logic                 IN_DST_RDY,
    output logic [7:0]           EMAC_DATA,
    output logic                 EMAC_DVLD,
    input  logic                 EMAC_ACK,
    output logic                 EMAC_FIRSTBYTE,
    output logic                 EMAC_UNDERRUN,
    input  logic                 EMAC_COLLISION,
    input  logic                 EMAC_RETRANSMIT,
    output logic [7:0]           EMAC_IFGDELAY,
    input  logic [7:0]           CFG_IFG,
    input  logic                 CFG_IFG_WE,
    input  logic                 CNT_CLR,
    output logic [CNT_WIDTH-1:0] CNT_FRAMES,
    output logic [CNT_WIDTH-1:0] CNT_UNDERRUN,
    output logic [CNT_WIDTH-1:0] CNT_COLLISION,
    output logic [CNT_WIDTH-1:0] CNT_RETRANSMIT
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        SEND     = 2'd2,
        DRAIN    = 2'd3
    } state_e;

    localparam int CI_FRM = 0;
    localparam int CI_UND = 1;
    localparam int CI_COL = 2;
    localparam int CI_RTX = 3;

    state_e               state_q, state_d;
    logic [7:0]           ifg_q;
    logic [CNT_WIDTH-1:0] cnt_q [4];

    logic       dst_rdy, dvld, firstbyte, underrun;
    logic [3:0] inc;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dst_rdy   = 1'b0;
        dvld      = 1'b0;
        firstbyte = 1'b0;
        underrun  = 1'b0;
        inc       = '0;
        case (state_q)
            IDLE: begin
                dst_rdy = IN_SRC_RDY & ~IN_SOF;
                if (ENABLE && IN_SRC_RDY && IN_SOF) begin
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK, SEND: begin
                if (EMAC_COLLISION) begin
                    // Collision beats ACK, data and underrun; the byte on the
                    // bus is swallowed so the drain starts at the next one.
                    dst_rdy     = IN_SRC_RDY;
                    inc[CI_COL] = 1'b1;
                    inc[CI_RTX] = EMAC_RETRANSMIT;
                    state_d     = (IN_SRC_RDY && IN_EOF) ? IDLE : DRAIN;
                end else if (state_q == WAIT_ACK) begin
                    dvld      = 1'b1;
                    firstbyte = 1'b1;
                    dst_rdy   = EMAC_ACK;
                    if (EMAC_ACK) begin
                        if (IN_EOF) begin
                            inc[CI_FRM] = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = SEND;
                        end
                    end
                end else begin
                    dst_rdy = 1'b1;
                    if (IN_SRC_RDY) begin
                        dvld = 1'b1;
                        if (IN_EOF) begin
                            inc[CI_FRM] = 1'b1;
                            state_d     = IDLE;
                        end
                    end else begin
                        underrun    = 1'b1;
                        inc[CI_UND] = 1'b1;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                dst_rdy = 1'b1;
                if (IN_SRC_RDY && IN_EOF) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ifg_q <= IFG_DEFAULT;
        end else if (CFG_IFG_WE) begin
            ifg_q <= CFG_IFG;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (CNT_CLR) begin
                    cnt_q[i] <= '0;
                end else if (inc[i] && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Outputs are combinational from state; gating with RESET makes them
    // take their reset values the moment reset asserts, not at the next edge.
    assign IN_DST_RDY     = RESET & dst_rdy;
    assign EMAC_DVLD      = RESET & dvld;
    assign EMAC_FIRSTBYTE = RESET & firstbyte;
    assign EMAC_UNDERRUN  = RESET & underrun;
    assign EMAC_DATA      = RESET ? IN_DATA : 8'h00;
    assign EMAC_IFGDELAY  = ifg_q;

    assign CNT_FRAMES     = cnt_q[CI_FRM];
    assign CNT_UNDERRUN   = cnt_q[CI_UND];
    assign CNT_COLLISION  = cnt_q[CI_COL];
    assign CNT_RETRANSMIT = cnt_q[CI_RTX];

endmodule

// File: tb/tb_emac_tx_ctrl.sv
module tb_emac_tx_ctrl;

    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          ENABLE;
    logic [7:0]    IN_DATA;
    logic          IN_SOF, IN_EOF, IN_SRC_RDY, IN_DST_RDY;
    logic [7:0]    EMAC_DATA;
    logic          EMAC_DVLD, EMAC_ACK, EMAC_FIRSTBYTE, EMAC_UNDERRUN;
    logic          EMAC_COLLISION, EMAC_RETRANSMIT;
    logic [7:0]    EMAC_IFGDELAY, CFG_IFG;
    logic          CFG_IFG_WE, CNT_CLR;
    logic [CW-1:0] CNT_FRAMES, CNT_UNDERRUN, CNT_COLLISION, CNT_RETRANSMIT;

    emac_tx_ctrl #(.CNT_WIDTH(CW), .IFG_DEFAULT(8'd0)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
        .IN_DATA(IN_DATA), .IN_SOF(IN_SOF), .IN_EOF(IN_EOF),
        .IN_SRC_RDY(IN_SRC_RDY), .IN_DST_RDY(IN_DST_RDY),
        .EMAC_DATA(EMAC_DATA), .EMAC_DVLD(EMAC_DVLD), .EMAC_ACK(EMAC_ACK),
        .EMAC_FIRSTBYTE(EMAC_FIRSTBYTE), .EMAC_UNDERRUN(EMAC_UNDERRUN),
        .EMAC_COLLISION(EMAC_COLLISION), .EMAC_RETRANSMIT(EMAC_RETRANSMIT),
        .EMAC_IFGDELAY(EMAC_IFGDELAY), .CFG_IFG(CFG_IFG), .CFG_IFG_WE(CFG_IFG_WE),
        .CNT_CLR(CNT_CLR), .CNT_FRAMES(CNT_FRAMES), .CNT_UNDERRUN(CNT_UNDERRUN),
        .CNT_COLLISION(CNT_COLLISION), .CNT_RETRANSMIT(CNT_RETRANSMIT)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q [$];

    // expected counter model
    int ef = 0, eu = 0, ec = 0, er = 0;

    // per-frame options, reset by clear_opts
    int   opt_gap, opt_col, opt_ifg, opt_rst;
    bit   opt_rtx, opt_clr;
    logic [7:0] opt_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= MAX) ? MAX : v + 1;
    endfunction

    task automatic clear_opts();
        opt_gap = -1; opt_col = -1; opt_ifg = -1; opt_rst = -1;
        opt_rtx = 1'b0; opt_clr = 1'b0; opt_base = 8'h00;
    endtask

    task automatic drive_idle();
        IN_SRC_RDY = 1'b0; IN_SOF = 1'b0; IN_EOF = 1'b0; IN_DATA = 8'h00;
        EMAC_ACK = 1'b0; EMAC_COLLISION = 1'b0; EMAC_RETRANSMIT = 1'b0;
        CFG_IFG_WE = 1'b0; CNT_CLR = 1'b0;
    endtask

    task automatic check_cnts(input string tag);
        check({tag, "_frames"}, CNT_FRAMES, ef);
        check({tag, "_underrun"}, CNT_UNDERRUN, eu);
        check({tag, "_collision"}, CNT_COLLISION, ec);
        check({tag, "_retransmit"}, CNT_RETRANSMIT, er);
    endtask

    // Presents one frame byte by byte, starting at a negedge. Expected EMAC
    // bytes go into the scoreboard up front; the monitor pops on every byte
    // the EMAC actually takes (ACKed first byte or DVLD in SEND).
    task automatic run_frame(input int n, input int ack_dly);
        int idx = 0, fb = 0, cyc = 0, lim;
        bit gap_done = 0, col_done = 0, ifg_done = 0, done = 0;
        bit gap_now, col_now, consumed;
        lim = (opt_rst >= 0) ? opt_rst : (opt_gap >= 0) ? opt_gap : (opt_col >= 0) ? opt_col : n;
        for (int i = 0; i < lim; i++) exp_q.push_back(8'(opt_base + i));
        while (!done && cyc < 400) begin
            cyc++;
            gap_now = (opt_gap == idx) && !gap_done;
            col_now = (opt_col == idx) && !col_done;
            IN_SRC_RDY      = !gap_now;
            IN_DATA         = 8'(opt_base + idx);
            IN_SOF          = (idx == 0);
            IN_EOF          = (idx == n - 1);
            EMAC_ACK        = 1'b0;
            EMAC_COLLISION  = col_now;
            EMAC_RETRANSMIT = col_now & opt_rtx;
            CFG_IFG         = 8'h0C;
            CFG_IFG_WE      = (opt_ifg == idx) && !ifg_done;
            CNT_CLR         = opt_clr;
            #1;
            if (cyc == 1) check("idle_dvld", EMAC_DVLD, 0);
            if (EMAC_FIRSTBYTE) begin
                if (fb == ack_dly) EMAC_ACK = 1'b1;
                fb++;
            end
            #1;
            if (opt_rst == idx) begin
                RESET = 1'b0;
                #1;
                check("rst_dst_rdy", IN_DST_RDY, 0);
                check("rst_dvld", EMAC_DVLD, 0);
                check("rst_data", EMAC_DATA, 0);
                check("rst_firstbyte", EMAC_FIRSTBYTE, 0);
                done = 1;
                @(negedge CLK);
                RESET = 1'b1;
            end else begin
                if ((EMAC_DVLD && !EMAC_FIRSTBYTE) || (EMAC_FIRSTBYTE && EMAC_ACK)) begin
                    if (exp_q.size() == 0) check("extra_byte", exp_q.size(), 1);
                    else check("data", EMAC_DATA, exp_q.pop_front());
                end
                check("underrun", EMAC_UNDERRUN, gap_now);
                if (col_now) check("col_dvld", EMAC_DVLD, 0);
                consumed = IN_DST_RDY && IN_SRC_RDY;
                @(posedge CLK);
                if (consumed) begin
                    if (idx == n - 1) done = 1;
                    idx++;
                end
                if (gap_now) gap_done = 1;
                if (col_now && consumed) col_done = 1;
                if (CFG_IFG_WE) begin
                    #1;
                    check("ifg_load", EMAC_IFGDELAY, 8'h0C);
                    ifg_done = 1;
                end
                @(negedge CLK);
            end
        end
        check("frame_done", done, 1);
        check("fb_cycles", fb, ack_dly + 1);
        check("sb_empty", exp_q.size(), 0);
        exp_q.delete();
        drive_idle();
        if (opt_clr) begin
            ef = 0; eu = 0; ec = 0; er = 0;
        end else if (opt_rst < 0) begin
            if (opt_gap >= 0) eu = sat(eu);
            else if (opt_col >= 0) begin
                ec = sat(ec);
                if (opt_rtx) er = sat(er);
            end else ef = sat(ef);
        end
        clear_opts();
    endtask

    initial begin
        clear_opts();
        drive_idle();
        ENABLE  = 1'b1;
        CFG_IFG = 8'h00;
        RESET   = 1'b0;
        IN_SRC_RDY = 1'b1; IN_DATA = 8'hAA;
        #2;
        check("reset_dst_rdy", IN_DST_RDY, 0);
        check("reset_dvld", EMAC_DVLD, 0);
        check("reset_data", EMAC_DATA, 0);
        check("reset_underrun", EMAC_UNDERRUN, 0);
        check("reset_ifg", EMAC_IFGDELAY, 0);
        check_cnts("reset");
        @(negedge CLK);
        drive_idle();
        @(negedge CLK);
        RESET = 1'b1;

        // ENABLE=0 holds off a pending SOF
        ENABLE = 1'b0;
        IN_SRC_RDY = 1'b1; IN_SOF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("disabled_fb", EMAC_FIRSTBYTE, 0);
            check("disabled_dst", IN_DST_RDY, 0);
            @(negedge CLK);
        end
        drive_idle();
        ENABLE = 1'b1;
        @(negedge CLK);

        // 64-byte frame, ACK 3 cycles after DVLD
        run_frame(64, 3);
        #1;
        check("post_frame_dvld", EMAC_DVLD, 0);
        check_cnts("f64");
        @(negedge CLK);

        // one-byte frames, including back-to-back
        opt_base = 8'h80; run_frame(1, 0);
        #1; check("one_byte_idle", EMAC_FIRSTBYTE, 0);
        @(negedge CLK);
        opt_base = 8'h90; run_frame(1, 2);
        opt_base = 8'hA0; run_frame(1, 1);
        check_cnts("one_byte");

        // underrun after byte 10 of 20
        opt_base = 8'h10; opt_gap = 10; run_frame(20, 1);
        check_cnts("underrun");

        // collision + retransmit at byte 5 of 30
        opt_base = 8'h40; opt_col = 4; opt_rtx = 1'b1; run_frame(30, 0);
        check_cnts("col_rtx");

        // collision on the EOF byte; the next frame must start from IDLE
        opt_base = 8'h60; opt_col = 7; run_frame(8, 0);
        opt_base = 8'h70; run_frame(5, 2);
        check_cnts("col_eof");

        // IFG write mid-frame
        opt_base = 8'hC0; opt_ifg = 10; run_frame(30, 1);
        check("ifg_hold", EMAC_IFGDELAY, 8'h0C);
        check_cnts("ifg");

        // saturation and clear-beats-increment
        for (int i = 0; i < 12; i++) begin
            opt_base = 8'(i); run_frame(1, 0);
        end
        check_cnts("sat");
        opt_clr = 1'b1; run_frame(1, 0);
        check_cnts("clr");

        // reset in SEND, stray bytes dropped, then a clean frame
        opt_base = 8'h20; opt_rst = 5; run_frame(12, 1);
        check("rst_ifg", EMAC_IFGDELAY, 0);
        check_cnts("rst");
        IN_SRC_RDY = 1'b1; IN_SOF = 1'b0;
        for (int i = 0; i < 3; i++) begin
            IN_DATA = 8'(8'hE0 + i);
            #1;
            check("stray_dst", IN_DST_RDY, 1);
            check("stray_dvld", EMAC_DVLD, 0);
            @(negedge CLK);
        end
        drive_idle();
        @(negedge CLK);
        opt_base = 8'h30; run_frame(10, 0);
        check_cnts("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
